// File: rtl/backoff_ctl.sv
// backoff_ctl: random-backoff engine for DCF/EDCA channel access.
// Draws 0..2^cw_exp-1 slots from a 16-bit Galois LFSR, waits an IFS of
// continuous idle medium, then counts slots down while idle and emits
// a one-cycle backoff_done grant.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   cw_exp            contention-window exponent (clamped to SLOT_W)
//   backoff_start     begin/restart a backoff with a fresh draw
//   backoff_abort     cancel, back to IDLE, no grant
//   ch_idle           CCA result, 1 = medium idle
//   ifs_cycles        IFS length in clk cycles (0 acts as 1)
//   slot_cycles       slot length in clk cycles (0 acts as 1)
//   backoff_done      registered one-cycle grant pulse
//   backoff_busy      state is not IDLE
//   slots_left        remaining backoff slots
//   state             IDLE=0, IFS=1, COUNT=2
module backoff_ctl #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SLOT_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cw_exp,
    input  logic              backoff_start,
    input  logic              backoff_abort,
    input  logic              ch_idle,
    input  logic [13:0]       ifs_cycles,
    input  logic [13:0]       slot_cycles,
    output logic              backoff_done,
    output logic              backoff_busy,
    output logic [SLOT_W-1:0] slots_left,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IFS   = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    localparam logic [15:0]       LFSR_MASK = 16'hB400;
    localparam logic [4:0]        SLOT_W5   = 5'(SLOT_W);
    localparam logic [SLOT_W-1:0] SLOT_ONES = '1;
    localparam logic [SLOT_W-1:0] SLOT_ONE  = 1;

    logic [15:0]       lfsr_q, lfsr_d;
    logic [1:0]        state_q, state_d;
    logic [13:0]       ifs_cnt_q, ifs_cnt_d;
    logic [13:0]       slot_cnt_q, slot_cnt_d;
    logic [SLOT_W-1:0] slots_q, slots_d;
    logic              done_q, done_d;

    logic [4:0]        exp_clamp;
    logic [SLOT_W-1:0] draw_mask;
    logic [SLOT_W-1:0] draw;
    logic [13:0]       ifs_last;
    logic [13:0]       slot_last;
    logic              ifs_end;
    logic              slot_end;

    // Right-shifting Galois LFSR; free-running in every state.
    assign lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ LFSR_MASK)
                              : {1'b0, lfsr_q[15:1]};

    assign exp_clamp = ({1'b0, cw_exp} > SLOT_W5) ? SLOT_W5
                                                  : {1'b0, cw_exp};
    // Shifting all-ones left leaves zeros in the low exp_clamp bits;
    // inverting gives the 2^exp-1 mask without a wider intermediate.
    assign draw_mask = ~(SLOT_ONES << exp_clamp);
    assign draw      = lfsr_q[SLOT_W-1:0] & draw_mask;

    // Zero lengths behave as one cycle. The >= compare makes the
    // counters saturate if the lengths shrink mid-count.
    assign ifs_last  = (ifs_cycles == 14'd0) ? 14'd0 : ifs_cycles - 14'd1;
    assign slot_last = (slot_cycles == 14'd0) ? 14'd0 : slot_cycles - 14'd1;
    assign ifs_end   = (ifs_cnt_q >= ifs_last);
    assign slot_end  = (slot_cnt_q >= slot_last);

    always_comb begin
        state_d    = state_q;
        ifs_cnt_d  = ifs_cnt_q;
        slot_cnt_d = slot_cnt_q;
        slots_d    = slots_q;
        done_d     = 1'b0;

        if (backoff_abort) begin
            state_d    = ST_IDLE;
            ifs_cnt_d  = 14'd0;
            slot_cnt_d = 14'd0;
            slots_d    = '0;
        end else if (backoff_start) begin
            state_d    = ST_IFS;
            ifs_cnt_d  = 14'd0;
            slot_cnt_d = 14'd0;
            slots_d    = draw;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ifs_cnt_d  = 14'd0;
                    slot_cnt_d = 14'd0;
                end
                ST_IFS: begin
                    if (!ch_idle) begin
                        ifs_cnt_d = 14'd0;
                    end else if (!ifs_end) begin
                        ifs_cnt_d = ifs_cnt_q + 14'd1;
                    end else begin
                        ifs_cnt_d  = 14'd0;
                        slot_cnt_d = 14'd0;
                        if (slots_q == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (!ch_idle) begin
                        // Partial slot is discarded; slots_left frozen.
                        slot_cnt_d = 14'd0;
                        ifs_cnt_d  = 14'd0;
                        state_d    = ST_IFS;
                    end else if (!slot_end) begin
                        slot_cnt_d = slot_cnt_q + 14'd1;
                    end else begin
                        slot_cnt_d = 14'd0;
                        slots_d    = slots_q - SLOT_ONE;
                        if (slots_q == SLOT_ONE) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    ifs_cnt_d  = 14'd0;
                    slot_cnt_d = 14'd0;
                    slots_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q     <= LFSR_SEED;
            state_q    <= ST_IDLE;
            ifs_cnt_q  <= 14'd0;
            slot_cnt_q <= 14'd0;
            slots_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            state_q    <= state_d;
            ifs_cnt_q  <= ifs_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            slots_q    <= slots_d;
            done_q     <= done_d;
        end
    end

    assign backoff_done = done_q;
    assign backoff_busy = (state_q != ST_IDLE);
    assign slots_left   = slots_q;
    assign state        = state_q;

endmodule

// File: tb/tb_backoff_ctl.sv
// tb_backoff_ctl: directed bench for backoff_ctl with a timing-level
// reference model checked against the DUT on every falling edge.
module tb_backoff_ctl;

    localparam int          SW   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cw_exp;
    logic        backoff_start;
    logic        backoff_abort;
    logic        ch_idle;
    logic [13:0] ifs_cycles;
    logic [13:0] slot_cycles;
    logic        backoff_done;
    logic        backoff_busy;
    logic [SW-1:0] slots_left;
    logic [1:0]  state;

    backoff_ctl #(.LFSR_SEED(SEED), .SLOT_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cw_exp       (cw_exp),
        .backoff_start(backoff_start),
        .backoff_abort(backoff_abort),
        .ch_idle      (ch_idle),
        .ifs_cycles   (ifs_cycles),
        .slot_cycles  (slot_cycles),
        .backoff_done (backoff_done),
        .backoff_busy (backoff_busy),
        .slots_left   (slots_left),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a backoff is "active" with a slot budget m_base
    // and a count m_run of idle cycles since the start or last busy
    // cycle. Everything observable follows arithmetically from those.
    logic [15:0] m_lfsr = SEED;
    bit          m_act  = 0;
    int          m_base = 0;
    int          m_run  = 0;
    bit          m_done = 0;

    function automatic int eff_ifs();
        return (ifs_cycles == 14'd0) ? 1 : int'(ifs_cycles);
    endfunction

    function automatic int eff_slot();
        return (slot_cycles == 14'd0) ? 1 : int'(slot_cycles);
    endfunction

    function automatic int draw_of(input logic [15:0] l,
                                   input logic [3:0] e);
        int k;
        k = (int'(e) > SW) ? SW : int'(e);
        return int'(l) % (1 << k);
    endfunction

    function automatic int exp_state();
        if (!m_act) return 0;
        return (m_run < eff_ifs()) ? 1 : 2;
    endfunction

    function automatic int exp_slots();
        if (!m_act) return 0;
        if (m_run < eff_ifs()) return m_base;
        return m_base - (m_run - eff_ifs()) / eff_slot();
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_lfsr = SEED;
            m_act  = 0;
            m_base = 0;
            m_run  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (backoff_abort) begin
                m_act  = 0;
                m_base = 0;
                m_run  = 0;
            end else if (backoff_start) begin
                m_act  = 1;
                m_base = draw_of(m_lfsr, cw_exp);
                m_run  = 0;
            end else if (m_act) begin
                if (!ch_idle) begin
                    if (m_run >= eff_ifs())
                        m_base -= (m_run - eff_ifs()) / eff_slot();
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run >= eff_ifs() &&
                        m_run - eff_ifs() == m_base * eff_slot()) begin
                        m_done = 1;
                        m_act  = 0;
                        m_base = 0;
                        m_run  = 0;
                    end
                end
            end
            m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ 16'hB400)
                               : {1'b0, m_lfsr[15:1]};
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            check("cmp_state", 32'(state), exp_state());
            check("cmp_slots", 32'(slots_left), exp_slots());
            check("cmp_done", 32'(backoff_done), 32'(m_done));
            check("cmp_busy", 32'(backoff_busy), 32'(m_act));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n = edges since the start edge when done is first seen.
    task automatic wait_done(input int n0, input int bound, output int n);
        n = n0;
        while (backoff_done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    // Start repeatedly until the model predicts a draw >= min_n.
    task automatic get_draw(input int min_n, output int n);
        n = -1;
        for (int t = 0; t < 50; t++) begin
            backoff_start = 1'b1;
            tick();
            backoff_start = 1'b0;
            n = exp_slots();
            if (n >= min_n) break;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n, nd, npulse, distinct, maxd;
    bit seen [0:1023];

    initial begin
        rst           = 1'b1;
        cw_exp        = 4'd3;
        backoff_start = 1'b0;
        backoff_abort = 1'b0;
        ch_idle       = 1'b1;
        ifs_cycles    = 14'd2;
        slot_cycles   = 14'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_slots", 32'(slots_left), 0);
        check("rst_busy", 32'(backoff_busy), 0);
        check("rst_done", 32'(backoff_done), 0);

        // First draw comes straight from the seed: 0xACE1 & 7 = 1.
        rst           = 1'b0;
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        check("pin_draw", 32'(slots_left), 1);
        check("pin_state", 32'(state), 1);
        wait_done(0, 100, n);
        check("pin_done_lat", n, 5);
        check("pin_done_idle", 32'(state), 0);

        // Zero draw, I=4.
        cw_exp     = 4'd0;
        ifs_cycles = 14'd4;
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        check("zero_slots", 32'(slots_left), 0);
        wait_done(0, 100, n);
        check("zero_done_lat", n, 4);
        tick();
        check("zero_one_cycle", 32'(backoff_done), 0);

        // Full count, several draws.
        cw_exp     = 4'd3;
        ifs_cycles = 14'd2;
        for (int r = 0; r < 4; r++) begin
            backoff_start = 1'b1;
            tick();
            backoff_start = 1'b0;
            nd = exp_slots();
            check("full_le7", 32'(slots_left <= 7), 1);
            wait_done(0, 200, n);
            check("full_done_lat", n, 2 + 3 * nd);
            tick();
        end

        // Busy freeze midway through slot 2.
        get_draw(3, nd);
        check("busy_draw_ge3", 32'(nd >= 3), 1);
        repeat (6) tick();
        ch_idle = 1'b0;
        repeat (5) tick();
        check("busy_state", 32'(state), 1);
        check("busy_slots", 32'(slots_left), nd - 1);
        ch_idle = 1'b1;
        wait_done(11, 300, n);
        check("busy_done_lat", n, 3 * nd + 10);
        tick();

        // Busy during IFS only restarts the IFS.
        cw_exp     = 4'd0;
        ifs_cycles = 14'd4;
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        ch_idle = 1'b0;
        repeat (2) tick();
        ch_idle = 1'b1;
        wait_done(2, 100, n);
        check("ifs_busy_lat", n, 6);

        // Done coinciding with a new start.
        ifs_cycles    = 14'd2;
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        check("dvs_state", 32'(state), 1);
        check("dvs_done_low", 32'(backoff_done), 0);
        wait_done(0, 100, n);
        check("dvs_done_lat", n, 2);
        tick();

        // Zero lengths act as one cycle.
        cw_exp      = 4'd2;
        ifs_cycles  = 14'd0;
        slot_cycles = 14'd0;
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        nd = exp_slots();
        wait_done(0, 100, n);
        check("len0_done_lat", n, 1 + nd);
        tick();

        // Clamp and range with start held every cycle.
        cw_exp      = 4'd15;
        ifs_cycles  = 14'd2;
        slot_cycles = 14'd3;
        distinct = 0;
        maxd     = 0;
        backoff_start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (slots_left > 1023) check("clamp_le", 32'(slots_left), 1023);
            if (!seen[int'(slots_left)]) distinct++;
            seen[int'(slots_left)] = 1'b1;
            if (int'(slots_left) > maxd) maxd = int'(slots_left);
        end
        backoff_start = 1'b0;
        check("clamp_distinct", 32'(distinct > 300), 1);
        check("clamp_max_hi", 32'(maxd > 900), 1);
        backoff_abort = 1'b1;
        tick();
        backoff_abort = 1'b0;

        // Abort during COUNT.
        cw_exp = 4'd10;
        get_draw(2, nd);
        repeat (3) tick();
        check("abort_pre_count", 32'(state), 2);
        backoff_abort = 1'b1;
        tick();
        backoff_abort = 1'b0;
        check("abort_state", 32'(state), 0);
        check("abort_slots", 32'(slots_left), 0);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (backoff_done === 1'b1) npulse++;
        end
        check("abort_no_done", npulse, 0);

        // Abort and start together.
        backoff_start = 1'b1;
        backoff_abort = 1'b1;
        tick();
        backoff_start = 1'b0;
        backoff_abort = 1'b0;
        check("abort_start_state", 32'(state), 0);

        // Start during COUNT restarts with a new draw.
        get_draw(1, nd);
        repeat (3) tick();
        check("restart_pre", 32'(state), 2);
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        nd = exp_slots();
        check("restart_state", 32'(state), 1);
        check("restart_slots", 32'(slots_left), nd);
        wait_done(0, 5000, n);
        check("restart_done_lat", n, 2 + 3 * nd);
        tick();

        // Async reset mid-COUNT, then a draw from the reloaded seed.
        get_draw(2, nd);
        repeat (3) tick();
        check("rst_pre_count", 32'(state), 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_slots", 32'(slots_left), 0);
        check("arst_busy", 32'(backoff_busy), 0);
        check("arst_done", 32'(backoff_done), 0);
        #2;
        rst           = 1'b0;
        backoff_start = 1'b1;
        tick();
        backoff_start = 1'b0;
        // 0xACE1 & 0x3FF = 225
        check("arst_seed_draw", 32'(slots_left), 225);
        backoff_abort = 1'b1;
        tick();
        backoff_abort = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
